// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU/UART scheduler: widths, FSM states,
// ALU opcodes and the result byte selector.
package alu_sched_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_CAPT     = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT_ACC = 3'd4,
    S_WAIT_TX  = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  // Opcodes are only forwarded by the scheduler; the ALU gives them meaning.
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  function automatic logic [DATA_W-1:0] res_byte(input logic [RES_W-1:0] r,
                                                 input logic             hi);
    return hi ? r[RES_W-1:DATA_W] : r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/alu_uart_sched_if.sv
// Requester, ALU, UART and completion signals of the scheduler, bundled.
// master = scheduler side, slave = surrounding system.
interface alu_uart_sched_if;
  import alu_sched_pkg::*;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              req1_ready;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_opcode;
  logic [RES_W-1:0]  alu_result;

  logic              uart_start;
  logic [DATA_W-1:0] uart_data;
  logic              uart_busy;

  logic              done_valid;
  logic              done_id;
  logic [RES_W-1:0]  done_result;
  logic              sched_busy;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, uart_busy,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode,
    output uart_start, uart_data,
    output done_valid, done_id, done_result, sched_busy
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, uart_busy,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode,
    input  uart_start, uart_data,
    input  done_valid, done_id, done_result, sched_busy
  );

endinterface

// File: rtl/alu_uart_sched_arb.sv
// Two-input round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that did not win last time. last_grant moves only on update.
module rr_arbiter2 #(
  parameter logic FIRST_GRANT = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic       grant_id_o,
  output logic       grant_valid_o
);

  logic last_grant_q;
  logic last_grant_d;
  logic grant_id;

  always_comb begin
    grant_id = 1'b0;
    unique case (valid_i)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update_i) last_grant_d = grant_id;
  end

  // Seeding with the complement makes FIRST_GRANT win the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_grant_q <= ~FIRST_GRANT;
    else          last_grant_q <= last_grant_d;
  end

  assign grant_id_o    = grant_id;
  assign grant_valid_o = |valid_i;

endmodule

// File: rtl/alu_uart_sched.sv
// Shares one ALU and one UART_TX between two requesters: arbitrate, register
// operands, capture the 16-bit result, stream it byte-wise, report completion.
module alu_uart_sched
  import alu_sched_pkg::*;
#(
  parameter int   SEND_BYTES  = 2,
  parameter logic FIRST_GRANT = 1'b0
) (
  input logic              clock,
  input logic              reset_n,
  alu_uart_sched_if.master bus
);

  localparam logic CNT_INIT = (SEND_BYTES > 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              id_q, id_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              byte_cnt_q, byte_cnt_d;

  logic grant_id;
  logic grant_vld;
  logic rdy0;
  logic rdy1;
  logic xfer;
  logic start_c;
  logic tx_phase;

  rr_arbiter2 #(
    .FIRST_GRANT (FIRST_GRANT)
  ) u_arb (
    .clock         (clock),
    .reset_n       (reset_n),
    .valid_i       ({bus.req1_valid, bus.req0_valid}),
    .update_i      (xfer),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_vld)
  );

  // reset_n gates ready so nothing is offered while reset is held.
  assign rdy0 = reset_n & (state_q == S_IDLE) & grant_vld & ~grant_id & bus.req0_valid;
  assign rdy1 = reset_n & (state_q == S_IDLE) & grant_vld &  grant_id & bus.req1_valid;
  assign xfer = rdy0 | rdy1;

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    id_d       = id_q;
    result_d   = result_q;
    byte_cnt_d = byte_cnt_q;
    start_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          alu_a_d  = grant_id ? bus.req1_a  : bus.req0_a;
          alu_b_d  = grant_id ? bus.req1_b  : bus.req0_b;
          alu_op_d = grant_id ? bus.req1_op : bus.req0_op;
          id_d     = grant_id;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        result_d   = bus.alu_result;
        byte_cnt_d = CNT_INIT;
        state_d    = S_SEND;
      end
      S_SEND: begin
        // The UART may still be shifting out the previous byte.
        if (!bus.uart_busy) begin
          start_c = 1'b1;
          state_d = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        if (bus.uart_busy) state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (!bus.uart_busy) begin
          if (byte_cnt_q != 1'b0) begin
            byte_cnt_d = 1'b0;
            state_d    = S_SEND;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      id_q       <= 1'b0;
      result_q   <= '0;
      byte_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      id_q       <= id_d;
      result_q   <= result_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // uart_data is valid from the start cycle until the byte has left the UART.
  assign tx_phase = (state_q == S_SEND) || (state_q == S_WAIT_ACC) ||
                    (state_q == S_WAIT_TX);

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.uart_start  = start_c;
  assign bus.uart_data   = tx_phase ? res_byte(result_q, byte_cnt_q) : '0;
  assign bus.done_valid  = (state_q == S_DONE);
  assign bus.done_id     = id_q;
  assign bus.done_result = result_q;
  assign bus.sched_busy  = (state_q != S_IDLE);

endmodule
